sram_burst_ctrl: RTL and testbench

Burst access controller placed directly upstream of the team's single-port synchronous RAM (syncRAM): it is the only block that drives that RAM's CS/WE/RD/Addr/dataIn and consumes its dataOut. A client issues write or read bursts through a valid/ready request channel, streams write data through its own handshake, and receives read data as a registered valid-qualified stream. The controller handles RAM read latency, address wrap-around and out-of-range addresses.

---
 rtl/sram_burst_pkg.sv | 18 +
 rtl/sram_addr_seq.sv | 47 ++++
 rtl/sram_burst_ctrl.sv | 142 ++++++++++++++
 tb/tb_sram_burst_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_burst_pkg.sv
// Shared state encoding and default geometry for the SRAM burst controller.
// Defaults match the syncRAM instance that sits behind the controller.
package sram_burst_pkg;

  localparam int ADR_DEF  = 8;
  localparam int DAT_DEF  = 8;
  localparam int DPTH_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/sram_addr_seq.sv
// Burst address sequencer: loads start/len, advances with modulo-DPTH wrap.
// Ports: clk_i, rst_i, load_i, addr_i, len_i, adv_i -> cur_o, last_o.
module sram_addr_seq #(
  parameter int ADR  = 8,
  parameter int DPTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic [ADR-1:0] addr_i,
  input  logic [ADR-1:0] len_i,
  input  logic           adv_i,
  output logic [ADR-1:0] cur_o,
  output logic           last_o
);

  localparam logic [ADR-1:0] TOP = ADR'(DPTH - 1);

  logic [ADR-1:0] cur_q, cur_d;
  logic [ADR-1:0] rem_q, rem_d;

  always_comb begin
    cur_d = cur_q;
    rem_d = rem_q;
    if (load_i) begin
      cur_d = addr_i;
      rem_d = len_i;
    end else if (adv_i) begin
      cur_d = (cur_q == TOP) ? '0 : cur_q + 1'b1;
      rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_q <= '0;
      rem_q <= '0;
    end else begin
      cur_q <= cur_d;
      rem_q <= rem_d;
    end
  end

  assign cur_o  = cur_q;
  assign last_o = (rem_q == '0);

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst controller in front of a single-port syncRAM: request channel,
// write-beat handshake, registered read stream, done/err pulses, RAM strobes.
module sram_burst_ctrl
  import sram_burst_pkg::*;
#(
  parameter int ADR  = ADR_DEF,
  parameter int DAT  = DAT_DEF,
  parameter int DPTH = DPTH_DEF
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           reqValid,
  output logic           reqReady,
  input  logic           reqWr,
  input  logic [ADR-1:0] reqAddr,
  input  logic [ADR-1:0] reqLen,
  input  logic           wrValid,
  output logic           wrReady,
  input  logic [DAT-1:0] wrData,
  output logic           rspValid,
  output logic [DAT-1:0] rspData,
  output logic           done,
  output logic           err,
  output logic           ramCS,
  output logic           ramWE,
  output logic           ramRD,
  output logic [ADR-1:0] ramAddr,
  output logic [DAT-1:0] ramDataIn,
  input  logic [DAT-1:0] ramDataOut
);

  localparam logic [ADR:0] DPTH_W = (ADR+1)'(DPTH);

  state_t         state_q, state_d;
  logic           cs_q, cs_d;
  logic           we_q, we_d;
  logic           rd_q, rd_d;
  logic [ADR-1:0] addr_q, addr_d;
  logic [DAT-1:0] din_q, din_d;
  logic           p1_q, p2_q;
  logic           rsp_v_q;
  logic [DAT-1:0] rsp_d_q;
  logic           load, adv, last;
  logic [ADR-1:0] cur;

  sram_addr_seq #(.ADR(ADR), .DPTH(DPTH)) u_seq (
    .clk_i  (Clk),
    .rst_i  (Rst),
    .load_i (load),
    .addr_i (reqAddr),
    .len_i  (reqLen),
    .adv_i  (adv),
    .cur_o  (cur),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    rd_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (reqValid) begin
          load = 1'b1;
          if ({1'b0, reqAddr} >= DPTH_W)
            state_d = S_ERR;
          else
            state_d = reqWr ? S_WR : S_RD;
        end
      end
      S_WR: begin
        if (wrValid) begin
          cs_d   = 1'b1;
          we_d   = 1'b1;
          addr_d = cur;
          din_d  = wrData;
          adv    = 1'b1;
          if (last) state_d = S_FIN;
        end
      end
      S_RD: begin
        cs_d   = 1'b1;
        rd_d   = 1'b1;
        addr_d = cur;
        adv    = 1'b1;
        if (last) state_d = S_DRAIN;
      end
      // p1: read issued, awaiting RAM latch; p2: RAM data ready to capture
      S_DRAIN: begin
        if (!p1_q && !p2_q) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      rsp_v_q <= 1'b0;
      rsp_d_q <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      p1_q    <= cs_d && rd_d;
      p2_q    <= p1_q;
      rsp_v_q <= p2_q;
      if (p2_q) rsp_d_q <= ramDataOut;
    end
  end

  // reqReady is masked while Rst is high so every output reads 0 in reset
  assign reqReady  = (state_q == S_IDLE) && !Rst;
  assign wrReady   = (state_q == S_WR);
  assign done      = (state_q == S_FIN);
  assign err       = (state_q == S_ERR);
  assign rspValid  = rsp_v_q;
  assign rspData   = rsp_d_q;
  assign ramCS     = cs_q;
  assign ramWE     = we_q;
  assign ramRD     = rd_q;
  assign ramAddr   = addr_q;
  assign ramDataIn = din_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Self-checking bench for sram_burst_ctrl with a behavioural syncRAM behind it.
// Read data is checked against a scoreboard queue filled at request time.
module tb_sram_burst_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       reqValid, reqReady, reqWr;
  logic [7:0] reqAddr, reqLen;
  logic       wrValid, wrReady;
  logic [7:0] wrData;
  logic       rspValid;
  logic [7:0] rspData;
  logic       done, err;
  logic       ramCS, ramWE, ramRD;
  logic [7:0] ramAddr, ramDataIn, ramDataOut;

  int tests = 0;
  int fails = 0;
  int rsp_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [7:0] shadow [8];
  logic [7:0] mem [8];
  logic [7:0] expq [$];

  always #5 Clk = ~Clk;

  sram_burst_ctrl #(.ADR(8), .DAT(8), .DPTH(8)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqWr      (reqWr),
    .reqAddr    (reqAddr),
    .reqLen     (reqLen),
    .wrValid    (wrValid),
    .wrReady    (wrReady),
    .wrData     (wrData),
    .rspValid   (rspValid),
    .rspData    (rspData),
    .done       (done),
    .err        (err),
    .ramCS      (ramCS),
    .ramWE      (ramWE),
    .ramRD      (ramRD),
    .ramAddr    (ramAddr),
    .ramDataIn  (ramDataIn),
    .ramDataOut (ramDataOut)
  );

  // syncRAM, ADR=8 DAT=8 DPTH=8
  always @(posedge Clk) begin
    if (ramCS && ramWE) mem[ramAddr[2:0]] <= ramDataIn;
    if (ramCS && ramRD) ramDataOut <= mem[ramAddr[2:0]];
  end

  // scoreboard and pulse monitor
  always @(negedge Clk) begin
    if (rspValid) begin
      rsp_cnt++;
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: got %h, none required", rspData);
      end else begin
        logic [7:0] e;
        e = expq.pop_front();
        if (rspData !== e) begin
          fails++;
          $display("FAIL rsp_data: got %h, required %h", rspData, e);
        end
      end
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (ramWE && ramRD) begin
      tests++;
      fails++;
      $display("FAIL we_rd_overlap: both strobes 1, required not both");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input logic wr, input logic [7:0] a, input logic [7:0] l);
    int k;
    reqValid = 1'b1;
    reqWr = wr;
    reqAddr = a;
    reqLen = l;
    for (k = 0; k < 50; k++) begin
      if (reqReady) break;
      @(negedge Clk);
    end
    if (k == 50) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: reqReady 0, required 1");
    end
    @(negedge Clk);
    reqValid = 1'b0;
  endtask

  task automatic wr_burst(input logic [7:0] a, input logic [7:0] l,
                          input logic [7:0] d [4], input int gap);
    logic [7:0] ad;
    ad = a;
    do_req(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge Clk);
        tests++;
        if (ramCS !== 1'b0) begin
          fails++;
          $display("FAIL wr_gap_cs: got %b, required 0", ramCS);
        end
      end
      wrValid = 1'b1;
      wrData = d[i];
      @(negedge Clk);
      wrValid = 1'b0;
      shadow[ad[2:0]] = d[i];
      ad = (ad == 8'd7) ? 8'd0 : ad + 8'd1;
    end
    tests++;
    if ({done, ramCS, ramWE} !== 3'b111) begin
      fails++;
      $display("FAIL wr_done: done/cs/we %b, required 111",
               {done, ramCS, ramWE});
    end
    @(negedge Clk);
    tests++;
    if ({done, wrReady, reqReady} !== 3'b001) begin
      fails++;
      $display("FAIL wr_after: done/wrReady/reqReady %b, required 001",
               {done, wrReady, reqReady});
    end
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] l);
    logic [7:0] ad;
    ad = a;
    for (int i = 0; i <= int'(l); i++) begin
      expq.push_back(shadow[ad[2:0]]);
      ad = (ad == 8'd7) ? 8'd0 : ad + 8'd1;
    end
  endtask

  task automatic rd_burst(input logic [7:0] a, input logic [7:0] l,
                          output int first, output int dn);
    int r0;
    int t;
    first = -1;
    dn = -1;
    r0 = rsp_cnt;
    push_exp(a, l);
    do_req(1'b0, a, l);
    for (t = 0; t < 40; t++) begin
      if (rspValid && first < 0) first = t;
      if (done) begin
        dn = t;
        break;
      end
      @(negedge Clk);
    end
    tests++;
    if (dn < 0) begin
      fails++;
      $display("FAIL rd_done_timeout: done not seen, required within 40");
    end
    tests++;
    if (rsp_cnt - r0 !== int'(l) + 1) begin
      fails++;
      $display("FAIL rd_beats: got %0d, required %0d", rsp_cnt - r0, int'(l) + 1);
    end
    @(negedge Clk);
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    tests++;
    if ({reqReady, wrReady, rspValid, done, err, ramCS, ramWE, ramRD,
         ramAddr, ramDataIn, rspData} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: nonzero, required all 0");
    end
    Rst = 1'b0;
    @(negedge Clk);
    tests++;
    if (reqReady !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b, required 1", reqReady);
    end
  endtask

  task automatic test_write_read;
    logic [7:0] d [4];
    int f, dn;
    d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    wr_burst(8'd2, 8'd3, d, 0);
    rd_burst(8'd2, 8'd3, f, dn);
    tests++;
    if (f !== 3) begin
      fails++;
      $display("FAIL rd_latency: got %0d, required 3", f);
    end
    tests++;
    if (dn !== 7) begin
      fails++;
      $display("FAIL rd_done_time: got %0d, required 7", dn);
    end
  endtask

  task automatic test_stalls;
    logic [7:0] d [4];
    int f, dn;
    d = '{8'h5C, 8'hC5, 8'h00, 8'h00};
    wr_burst(8'd0, 8'd1, d, 2);
    rd_burst(8'd0, 8'd1, f, dn);
  endtask

  task automatic test_wrap;
    logic [7:0] d [4];
    int f, dn;
    d = '{8'd1, 8'd2, 8'd3, 8'd4};
    wr_burst(8'd6, 8'd3, d, 0);
    rd_burst(8'd7, 8'd1, f, dn);
    tests++;
    if (mem[0] !== 8'd3 || mem[1] !== 8'd4 || mem[6] !== 8'd1) begin
      fails++;
      $display("FAIL wrap_mem: got %h %h %h, required 03 04 01",
               mem[0], mem[1], mem[6]);
    end
  endtask

  task automatic test_error;
    int e0, d0;
    e0 = err_cnt;
    d0 = done_cnt;
    do_req(1'b0, 8'd8, 8'd0);
    tests++;
    if ({err, ramCS, done} !== 3'b100) begin
      fails++;
      $display("FAIL err_pulse: err/cs/done %b, required 100",
               {err, ramCS, done});
    end
    @(negedge Clk);
    tests++;
    if ({err, reqReady} !== 2'b01) begin
      fails++;
      $display("FAIL err_recover: err/reqReady %b, required 01",
               {err, reqReady});
    end
    repeat (2) @(negedge Clk);
    tests++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      fails++;
      $display("FAIL err_count: err %0d done %0d, required 1 0",
               err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_midburst;
    int r0, d0, e0;
    int f, dn;
    push_exp(8'd0, 8'd7);
    do_req(1'b0, 8'd0, 8'd7);
    repeat (4) @(negedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    tests++;
    if ({reqReady, wrReady, rspValid, done, err, ramCS, ramWE, ramRD,
         ramAddr, ramDataIn, rspData} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: nonzero, required all 0");
    end
    expq.delete();
    r0 = rsp_cnt;
    d0 = done_cnt;
    e0 = err_cnt;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    tests++;
    if (rsp_cnt != r0 || done_cnt != d0 || err_cnt != e0) begin
      fails++;
      $display("FAIL midreset_pulses: rsp %0d done %0d err %0d, required 0 0 0",
               rsp_cnt - r0, done_cnt - d0, err_cnt - e0);
    end
    rd_burst(8'd6, 8'd2, f, dn);
  endtask

  task automatic test_back_to_back;
    int t, rdy_t, dn_t, dn2;
    rdy_t = -1;
    dn_t = -1;
    dn2 = -1;
    push_exp(8'd4, 8'd3);
    do_req(1'b0, 8'd4, 8'd3);
    reqValid = 1'b1;
    reqWr = 1'b0;
    reqAddr = 8'd2;
    reqLen = 8'd0;
    for (t = 0; t < 40; t++) begin
      if (done) dn_t = t;
      if (reqReady) begin
        rdy_t = t;
        break;
      end
      @(negedge Clk);
    end
    tests++;
    if (rdy_t !== 8 || dn_t !== 7) begin
      fails++;
      $display("FAIL busy_ready: ready at %0d done at %0d, required 8 7",
               rdy_t, dn_t);
    end
    push_exp(8'd2, 8'd0);
    @(negedge Clk);
    reqValid = 1'b0;
    for (t = 0; t < 40; t++) begin
      if (done) begin
        dn2 = t;
        break;
      end
      @(negedge Clk);
    end
    tests++;
    if (dn2 !== 4) begin
      fails++;
      $display("FAIL held_req_done: got %0d, required 4", dn2);
    end
    @(negedge Clk);
    tests++;
    if (expq.size() !== 0) begin
      fails++;
      $display("FAIL queue_left: %0d entries, required 0", expq.size());
    end
  endtask

  initial begin
    Rst = 1'b1;
    reqValid = 1'b0;
    reqWr = 1'b0;
    reqAddr = '0;
    reqLen = '0;
    wrValid = 1'b0;
    wrData = '0;
    for (int i = 0; i < 8; i++) shadow[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    @(negedge Clk);
    test_reset();
    test_write_read();
    test_stalls();
    test_wrap();
    test_error();
    test_reset_midburst();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
